// File: rtl/ex_stage_datapath.sv
// rtl/ex_stage_datapath.sv - execute-stage datapath: operand muxes, ALU, branch target, NZVC flags
//
// Purpose:
//   Operand selection (immediate mux followed by EX/MEM and MEM/WB forwarding
//   muxes), 64-bit ALU, branch target PC + (BR_to_shift << 2), and the
//   registered N/Z/V/C condition flags written only when update is high.
//
// Configuration macro: EX_CBZ_BYPASS_EN
//   defined   : zero shows the live ALU zero while cbz_id is high
//   undefined : cbz_id is ignored; zero is always the registered Z flag
//
// Ports:
//   clk            in   1   clock; flags load on rising edge
//   reset          in   1   asynchronous active-high; clears the flags
//   ReadData1      in  64   register-file operand A
//   ReadData2      in  64   register-file operand B
//   PC             in  64   PC of the instruction in EX
//   ALU_or_DT      in  64   extended ALU immediate or DT offset
//   BR_to_shift    in  64   sign-extended branch offset in words
//   alu_result_mem in  64   forwarded result from EX/MEM
//   alu_result_wb  in  64   forwarded result from MEM/WB
//   ALUop          in   3   ALU operation select
//   forwardA       in   2   operand A forward select
//   forwardB       in   2   operand B forward select
//   ALUsrc         in   1   1: immediate, 0: ReadData2
//   update         in   1   load live flags at the clock edge
//   cbz_id         in   1   zero output shows live Z (CBZ)
//   alu_result     out 64   combinational ALU result
//   new_PC2        out 64   combinational branch target
//   negative       out  1   registered N
//   zero           out  1   registered Z, or live Z for CBZ
//   overflow       out  1   registered V
//   carry_out      out  1   registered C

module ex_stage_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] ReadData1,
  input  logic [63:0] ReadData2,
  input  logic [63:0] PC,
  input  logic [63:0] ALU_or_DT,
  input  logic [63:0] BR_to_shift,
  input  logic [63:0] alu_result_mem,
  input  logic [63:0] alu_result_wb,
  input  logic [2:0]  ALUop,
  input  logic [1:0]  forwardA,
  input  logic [1:0]  forwardB,
  input  logic        ALUsrc,
  input  logic        update,
  input  logic        cbz_id,
  output logic [63:0] alu_result,
  output logic [63:0] new_PC2,
  output logic        negative,
  output logic        zero,
  output logic        overflow,
  output logic        carry_out
);

  logic [63:0] b_sel;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic [63:0] b_eff;
  logic [64:0] addsub;
  logic [63:0] result;
  logic        live_n;
  logic        live_z;
  logic        live_v;
  logic        live_c;

  logic n_q, z_q, v_q, c_q;
  logic n_d, z_d, v_d, c_d;

  // The top two offset bits fall off the shift; they carry no information.
  logic br_unused;
  assign br_unused = ^BR_to_shift[63:62];

  // Immediate mux first, so forwarding overrides the immediate selection.
  assign b_sel = ALUsrc ? ALU_or_DT : ReadData2;

  always_comb begin
    op_a = ReadData1;
    case (forwardA)
      2'b01:   op_a = alu_result_mem;
      2'b10:   op_a = alu_result_wb;
      default: op_a = ReadData1;
    endcase
  end

  always_comb begin
    op_b = b_sel;
    case (forwardB)
      2'b01:   op_b = alu_result_mem;
      2'b10:   op_b = alu_result_wb;
      default: op_b = b_sel;
    endcase
  end

  // Subtraction is A + ~B + 1, so carry = 1 means no borrow.
  always_comb begin
    result = '0;
    addsub = '0;
    live_c = 1'b0;
    live_v = 1'b0;
    b_eff  = (ALUop == 3'b011) ? ~op_b : op_b;
    case (ALUop)
      3'b000: result = op_b;
      3'b010, 3'b011: begin
        addsub = {1'b0, op_a} + {1'b0, b_eff} + {64'd0, (ALUop == 3'b011)};
        result = addsub[63:0];
        live_c = addsub[64];
        // Overflow: both addends share a sign that the sum does not.
        live_v = (op_a[63] == b_eff[63]) && (result[63] != op_a[63]);
      end
      3'b100:  result = op_a & op_b;
      3'b101:  result = op_a | op_b;
      3'b110:  result = op_a ^ op_b;
      default: result = '0;
    endcase
  end

  assign live_n     = result[63];
  assign live_z     = (result == 64'd0);
  assign alu_result = result;
  assign new_PC2    = PC + {BR_to_shift[61:0], 2'b00};

  always_comb begin
    n_d = n_q;
    z_d = z_q;
    v_d = v_q;
    c_d = c_q;
    if (update) begin
      n_d = live_n;
      z_d = live_z;
      v_d = live_v;
      c_d = live_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q <= 1'b0;
      z_q <= 1'b0;
      v_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      n_q <= n_d;
      z_q <= z_d;
      v_q <= v_d;
      c_q <= c_d;
    end
  end

  assign negative  = n_q;
  assign overflow  = v_q;
  assign carry_out = c_q;

`ifdef EX_CBZ_BYPASS_EN
  // CBZ needs the zero test of the current result, not a prior S-op.
  assign zero = cbz_id ? live_z : z_q;
`else
  logic cbz_unused;
  assign cbz_unused = cbz_id;
  assign zero = z_q;
`endif

endmodule

// File: tb/tb_ex_stage_datapath.sv
// tb/tb_ex_stage_datapath.sv - scoreboard bench for ex_stage_datapath

module tb_ex_stage_datapath;

`ifdef EX_CBZ_BYPASS_EN
  localparam bit CBZ_ON = 1'b1;
`else
  localparam bit CBZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] ReadData1 = '0, ReadData2 = '0, PC = '0, ALU_or_DT = '0;
  logic [63:0] BR_to_shift = '0, alu_result_mem = '0, alu_result_wb = '0;
  logic [2:0]  ALUop = '0;
  logic [1:0]  forwardA = '0, forwardB = '0;
  logic        ALUsrc = 1'b0, update = 1'b0, cbz_id = 1'b0;
  logic [63:0] alu_result, new_PC2;
  logic        negative, zero, overflow, carry_out;

  ex_stage_datapath dut (
    .clk(clk), .reset(reset),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .PC(PC),
    .ALU_or_DT(ALU_or_DT), .BR_to_shift(BR_to_shift),
    .alu_result_mem(alu_result_mem), .alu_result_wb(alu_result_wb),
    .ALUop(ALUop), .forwardA(forwardA), .forwardB(forwardB),
    .ALUsrc(ALUsrc), .update(update), .cbz_id(cbz_id),
    .alu_result(alu_result), .new_PC2(new_PC2),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] res;
    logic [63:0] pc;
    logic [3:0]  flags;   // {N, zero output, V, C}
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input int id, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s: got %h expected %h", id, name, act, exp);
    end
  endtask

  // Monitor: the DUT's outputs are sampled mid-cycle whenever a vector is pending.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.id, "alu_result", alu_result, e.res);
      chk(e.id, "new_PC2", new_PC2, e.pc);
      chk(e.id, "negative", {63'd0, negative}, {63'd0, e.flags[3]});
      chk(e.id, "zero", {63'd0, zero}, {63'd0, e.flags[2]});
      chk(e.id, "overflow", {63'd0, overflow}, {63'd0, e.flags[1]});
      chk(e.id, "carry_out", {63'd0, carry_out}, {63'd0, e.flags[0]});
    end
  end

  int vid = 0;

  task automatic step(
    input logic rst, input logic [63:0] rd1, rd2, pc, imm, br, mem, wb,
    input logic [2:0] op, input logic [1:0] fa, fb,
    input logic src, upd, cbz,
    input logic [63:0] e_res, e_pc, input logic [3:0] e_flags);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; ReadData1 = rd1; ReadData2 = rd2; PC = pc; ALU_or_DT = imm;
    BR_to_shift = br; alu_result_mem = mem; alu_result_wb = wb; ALUop = op;
    forwardA = fa; forwardB = fb; ALUsrc = src; update = upd; cbz_id = cbz;
    e.id = vid; e.res = e_res; e.pc = e_pc; e.flags = e_flags;
    sb.push_back(e);
    vid++;
  endtask

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    //    rst  rd1                    rd2       pc                     imm   br      mem    wb     op      fa     fb     src  upd  cbz   res                    pc      {N,Zo,V,C}
    step(1, 0,                     0,        0,                     0,    0,      0,     0,     3'b000, 2'b00, 2'b00, 0,   1,   0,    0,                     0,      4'b0000);
    step(0, 64'h2AA,               64'h155,  0,                     0,    2,      0,     0,     3'b010, 2'b00, 2'b00, 0,   0,   0,    64'h3FF,               64'h8,  4'b0000);
    step(0, 64'h2AA,               64'h155,  0,                     1,    64'h80, 0,     0,     3'b010, 2'b00, 2'b00, 1,   1,   0,    64'h2AB,               64'h200,4'b0000);
    step(0, 64'hFFFF_FFFF_FFFF_FAAA,64'h155, 0,                     1,    0,      0,     0,     3'b010, 2'b00, 2'b00, 1,   0,   0,    64'hFFFF_FFFF_FFFF_FAAB,0,     4'b0000);
    step(0, 64'hFFFF_FFFF_FFFF_FAAA,64'h155, 0,                     1,    0,      64'h10,64'h20,3'b011, 2'b01, 2'b10, 1,   1,   0,    64'hFFFF_FFFF_FFFF_FFF0,0,     4'b0000);
    step(0, 5,                     5,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   1,   0,    0,                     0,      4'b1000);
    step(0, 6,                     5,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   0,   0,    1,                     0,      4'b0101);
    step(0, 6,                     5,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   0,   1,    1,                     0,      {1'b0, ~CBZ_ON, 2'b01});
    step(0, MAX,                   1,        0,                     0,    0,      0,     0,     3'b010, 2'b00, 2'b00, 0,   1,   0,    MIN,                   0,      4'b0101);
    step(0, MIN,                   1,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   1,   0,    MAX,                   0,      4'b1010);
    step(0, 64'hF0F0,              64'hFF00, 0,                     0,    0,      0,     0,     3'b100, 2'b00, 2'b00, 0,   1,   0,    64'hF000,              0,      4'b0011);
    step(0, 9,                     9,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   1,   1,    0,                     0,      {1'b0, CBZ_ON, 2'b00});
    step(0, 64'hF0F0,              64'h0F0F, 64'hFFFF_FFFF_FFFF_FFFC,0,   1,      0,     0,     3'b101, 2'b00, 2'b00, 0,   0,   0,    64'hFFFF,              0,      4'b0101);
    step(0, 64'hFF,                64'hFF,   64'h100,               0,    ONES,   0,     0,     3'b110, 2'b00, 2'b00, 0,   0,   0,    0,                     64'hFC, 4'b0101);
    step(0, 64'hFF,                1,        64'h100,               0,    ONES,   0,     0,     3'b111, 2'b00, 2'b00, 0,   0,   0,    0,                     64'hFC, 4'b0101);
    step(0, 64'hFF,                1,        64'h100,               0,    ONES,   0,     0,     3'b001, 2'b00, 2'b00, 0,   1,   0,    0,                     64'hFC, 4'b0101);
    step(0, 64'hFF,                MIN,      0,                     0,    0,      0,     0,     3'b000, 2'b11, 2'b11, 0,   1,   0,    MIN,                   0,      4'b0100);
    step(0, 10,                    64'h55,   64'h100,               3,    ONES,   64'h7, 64'h9, 3'b010, 2'b11, 2'b11, 1,   0,   0,    13,                    64'hFC, 4'b1000);
    step(0, MIN,                   1,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   1,   0,    MAX,                   0,      4'b1000);
    step(1, MIN,                   1,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   1,   0,    MAX,                   0,      4'b0000);
    step(0, MIN,                   1,        0,                     0,    0,      0,     0,     3'b011, 2'b00, 2'b00, 0,   0,   0,    MAX,                   0,      4'b0000);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
